// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-bus 7-segment display.
// Scans one digit at a time with a blanking gap and swaps in new values only at frame boundaries.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 6,
  parameter int CLK_DIV      = 5000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    lz_en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dot_in,
  output logic [3:0]              bcd_out,
  output logic                    dot_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done,
  output logic [1:0]              dbg_state,
  output logic                    dbg_pending
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  state_e                  state;
  logic [IW-1:0]           idx;
  logic [CW-1:0]           cnt;
  logic [4*NUM_DIGITS-1:0] disp_bcd;
  logic [NUM_DIGITS-1:0]   disp_dot;
  logic [4*NUM_DIGITS-1:0] pend_bcd;
  logic [NUM_DIGITS-1:0]   pend_dot;
  logic                    pending;

  logic                    commit;
  logic [4*NUM_DIGITS-1:0] next_bcd;
  logic [NUM_DIGITS-1:0]   next_dot;
  logic                    next_pending;
  logic [3:0]              sel_bcd;
  logic                    sel_dot;
  logic                    sel_zero_run;
  logic                    all_zero;
  logic [NUM_DIGITS-1:0]   sel_onehot;

  assign dbg_state   = state;
  assign dbg_pending = pending;
  assign sel_onehot  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;

  // The swap window is the first BLANK cycle of a new frame (frame_done high) or
  // any OFF cycle; a LOAD landing in that window bypasses the pending register.
  always_comb begin
    commit       = frame_done || (state == ST_OFF);
    next_bcd     = disp_bcd;
    next_dot     = disp_dot;
    next_pending = pending | load;
    if (commit) begin
      next_pending = 1'b0;
      if (load) begin
        next_bcd = bcd_in;
        next_dot = dot_in;
      end else if (pending) begin
        next_bcd = pend_bcd;
        next_dot = pend_dot;
      end
    end
  end

  // Walk from the top digit down so all_zero covers the digit and everything above it.
  always_comb begin
    sel_bcd      = 4'hF;
    sel_dot      = 1'b0;
    sel_zero_run = 1'b0;
    all_zero     = 1'b1;
    for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
      all_zero = all_zero && (next_bcd[4*j +: 4] == 4'h0);
      if (idx == IW'(j)) begin
        sel_bcd      = next_bcd[4*j +: 4];
        sel_dot      = next_dot[j];
        sel_zero_run = all_zero && (j != 0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_BLANK;
      idx        <= '0;
      cnt        <= '0;
      disp_bcd   <= '0;
      disp_dot   <= '0;
      pend_bcd   <= '0;
      pend_dot   <= '0;
      pending    <= 1'b0;
      digit_sel  <= '0;
      bcd_out    <= 4'hF;
      dot_out    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      disp_bcd   <= next_bcd;
      disp_dot   <= next_dot;
      pending    <= next_pending;
      frame_done <= 1'b0;
      if (load) begin
        pend_bcd <= bcd_in;
        pend_dot <= dot_in;
      end
      if (!enable) begin
        state     <= ST_OFF;
        idx       <= '0;
        cnt       <= '0;
        digit_sel <= '0;
        bcd_out   <= 4'hF;
        dot_out   <= 1'b0;
      end else begin
        case (state)
          ST_OFF: begin
            state <= ST_BLANK;
            idx   <= '0;
            cnt   <= '0;
          end
          ST_BLANK: begin
            if (cnt == BLANK_LAST) begin
              state     <= ST_SHOW;
              cnt       <= '0;
              digit_sel <= sel_onehot;
              bcd_out   <= (lz_en && sel_zero_run) ? 4'hF : sel_bcd;
              dot_out   <= sel_dot;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_SHOW: begin
            if (cnt == SHOW_LAST) begin
              state      <= ST_BLANK;
              cnt        <= '0;
              digit_sel  <= '0;
              bcd_out    <= 4'hF;
              dot_out    <= 1'b0;
              frame_done <= (idx == IDX_LAST);
              idx        <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state     <= ST_OFF;
            digit_sel <= '0;
            bcd_out   <= 4'hF;
            dot_out   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 4 digits, 8-clock SHOW and 2-clock BLANK.
module tb_seg_scan_ctrl;

  localparam int ND = 4;

  logic          clk;
  logic          rst;
  logic          enable;
  logic          lz_en;
  logic          load;
  logic [15:0]   bcd_in;
  logic [3:0]    dot_in;
  logic [3:0]    bcd_out;
  logic          dot_out;
  logic [3:0]    digit_sel;
  logic          frame_done;
  logic [1:0]    dbg_state;
  logic          dbg_pending;

  int n_vec;
  int n_miss;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dot;
    logic        lz;
    logic [15:0] exp_bcd;
    logic [3:0]  exp_dot;
  } vec_t;

  vec_t       vecs[8];
  logic [4:0] exp_q[$];

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .CLK_DIV     (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .lz_en      (lz_en),
    .load       (load),
    .bcd_in     (bcd_in),
    .dot_in     (dot_in),
    .bcd_out    (bcd_out),
    .dot_out    (dot_out),
    .digit_sel  (digit_sel),
    .frame_done (frame_done),
    .dbg_state  (dbg_state),
    .dbg_pending(dbg_pending)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // drivers
  task automatic pulse_load(input logic [15:0] b, input logic [3:0] d);
    bcd_in = b;
    dot_in = d;
    load   = 1'b1;
    tick();
    load   = 1'b0;
  endtask

  task automatic wait_fd();
    int i;
    i = 0;
    while (frame_done !== 1'b1 && i < 200) begin
      tick();
      i++;
    end
    check("wait_frame_done", 32'(frame_done), 32'd1);
  endtask

  task automatic wait_sel(input logic [3:0] want);
    int i;
    i = 0;
    while (digit_sel !== want && i < 200) begin
      tick();
      i++;
    end
    check("wait_digit_sel", 32'(digit_sel), 32'(want));
  endtask

  initial begin
    logic [15:0] model_val;
    logic [4:0]  exp_e;
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b1;
    enable = 1'b0;
    lz_en  = 1'b0;
    load   = 1'b0;
    bcd_in = '0;
    dot_in = '0;

    vecs[0] = '{16'h1234, 4'b0000, 1'b0, 16'h1234, 4'b0000};
    vecs[1] = '{16'h0070, 4'b0100, 1'b1, 16'hFF70, 4'b0100};
    vecs[2] = '{16'h0000, 4'b0001, 1'b1, 16'hFFF0, 4'b0001};
    vecs[3] = '{16'h0000, 4'b0000, 1'b0, 16'h0000, 4'b0000};
    vecs[4] = '{16'h09A0, 4'b0000, 1'b1, 16'hF9A0, 4'b0000};
    vecs[5] = '{16'h1002, 4'b1111, 1'b1, 16'h1002, 4'b1111};
    vecs[6] = '{16'h0F05, 4'b1010, 1'b1, 16'hFF05, 4'b1010};
    vecs[7] = '{16'h0500, 4'b0000, 1'b1, 16'hF500, 4'b0000};

    // reset state
    #12;
    check("rst_sel",     32'(digit_sel),   32'd0);
    check("rst_bcd",     32'(bcd_out),     32'hF);
    check("rst_dot",     32'(dot_out),     32'd0);
    check("rst_fd",      32'(frame_done),  32'd0);
    check("rst_pending", 32'(dbg_pending), 32'd0);
    check("rst_state",   32'(dbg_state),   32'd1);

    enable = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("first_blank_sel", 32'(digit_sel), 32'd0);
    tick();
    check("first_show_sel", 32'(digit_sel), 32'b0001);
    check("first_show_bcd", 32'(bcd_out),   32'h0);

    // exact frame timing with 1234
    pulse_load(16'h1234, 4'b0000);
    check("pending_set", 32'(dbg_pending), 32'd1);
    wait_fd();
    model_val = 16'h1234;
    for (int k = 0; k <= 40; k++) begin
      logic [9:0] exp_t;
      int d;
      int p;
      d = k / 10;
      p = k % 10;
      if (k == 40)
        exp_t = {1'b1, 4'b0000, 4'hF, 1'b0};
      else if (p < 2)
        exp_t = {(k == 0), 4'b0000, 4'hF, 1'b0};
      else
        exp_t = {1'b0, 4'(1 << d), 4'(model_val >> (4 * d)), 1'b0};
      check($sformatf("frame_cycle_%0d", k),
            32'({frame_done, digit_sel, bcd_out, dot_out}), 32'(exp_t));
      if (k == 1) check("pending_clear", 32'(dbg_pending), 32'd0);
      if (k < 40) tick();
    end

    // table: display values, dots and leading-zero suppression
    for (int v = 0; v < 8; v++) begin
      lz_en = vecs[v].lz;
      pulse_load(vecs[v].bcd, vecs[v].dot);
      for (int d = 0; d < ND; d++)
        exp_q.push_back({vecs[v].exp_bcd[4*d +: 4], vecs[v].exp_dot[d]});
      wait_fd();
      for (int d = 0; d < ND; d++) begin
        wait_sel(4'(1 << d));
        exp_e = exp_q.pop_front();
        check($sformatf("vec%0d_digit%0d", v, d), 32'({bcd_out, dot_out}), 32'(exp_e));
      end
    end
    lz_en = 1'b0;

    // mid-frame LOAD waits for the next frame
    pulse_load(16'h1111, 4'b0000);
    wait_fd();
    wait_sel(4'b0010);
    check("mid_d1_before", 32'(bcd_out), 32'h1);
    pulse_load(16'h2222, 4'b0000);
    check("mid_pending", 32'(dbg_pending), 32'd1);
    check("mid_d1_after", 32'(bcd_out), 32'h1);
    wait_sel(4'b0100);
    check("mid_d2", 32'(bcd_out), 32'h1);
    wait_sel(4'b1000);
    check("mid_d3", 32'(bcd_out), 32'h1);
    wait_sel(4'b0001);
    check("mid_next_d0", 32'(bcd_out), 32'h2);

    // LOAD on the frame_done cycle beats an older pending value
    pulse_load(16'h7777, 4'b0000);
    wait_fd();
    bcd_in = 16'h5555;
    load   = 1'b1;
    tick();
    load   = 1'b0;
    check("fd_load_pending", 32'(dbg_pending), 32'd0);
    wait_sel(4'b0001);
    check("fd_load_d0", 32'(bcd_out), 32'h5);

    // ENABLE drop during digit 2
    wait_sel(4'b0100);
    enable = 1'b0;
    tick();
    check("off_sel",   32'(digit_sel), 32'd0);
    check("off_bcd",   32'(bcd_out),   32'hF);
    check("off_state", 32'(dbg_state), 32'd0);
    tick();
    tick();
    check("off_hold_sel", 32'(digit_sel), 32'd0);
    enable = 1'b1;
    tick();
    check("restart_blank_state", 32'(dbg_state), 32'd1);
    check("restart_blank_sel",   32'(digit_sel), 32'd0);
    tick();
    check("restart_blank2_sel",  32'(digit_sel), 32'd0);
    tick();
    check("restart_show_sel", 32'(digit_sel), 32'b0001);
    check("restart_show_bcd", 32'(bcd_out),   32'h5);

    // async reset during SHOW
    wait_sel(4'b0010);
    #2 rst = 1'b1;
    #1;
    check("async_sel",   32'(digit_sel), 32'd0);
    check("async_bcd",   32'(bcd_out),   32'hF);
    check("async_state", 32'(dbg_state), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_blank", 32'(digit_sel), 32'd0);
    tick();
    check("post_rst_sel", 32'(digit_sel), 32'b0001);
    check("post_rst_bcd", 32'(bcd_out),   32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
